la5_stream_reader: RTL and testbench
====================================

LA5_STREAM_READER -- requirements
Module: la5_stream_reader

Interface
REQ-001 Parameter N, default 5: matrix dimension; the block reads N*N = 25 elements.
REQ-002 Parameter FIFO_DEPTH, default 4: output buffer entries, power of two.
REQ-003 clk  in  1: single clock; all logic on the rising edge.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 start  in  1: one-cycle request to begin a matrix sweep.
REQ-006 busy  out  1: high from the cycle after an accepted start until the last element is accepted downstream.
REQ-007 done  out  1: one-cycle pulse after the last element is accepted.
REQ-008 address  out  5: read index into the upstream LA5 result port, row-major (index = 5*row + col).
REQ-009 data_out  in  32: upstream read data; valid exactly one cycle after address is presented.
REQ-010 m_valid  out  1: output element valid.
REQ-011 m_ready  in  1: downstream ready.
REQ-012 m_data  out  32: element value.
REQ-013 m_row, m_col  out  3 each: element coordinates, 0..4.
REQ-014 m_last  out  1: marks element (4,4).
REQ-015 checksum  out  32: modulo-2^32 sum of all 25 elements; valid when done pulses; held until the next start.

Function
REQ-016 FSM states: IDLE, READ, DRAIN. IDLE->READ on start; READ->DRAIN after address 24 is issued; DRAIN->IDLE when the m_last beat is accepted.
REQ-017 start in READ or DRAIN is ignored; start coincident with a done pulse is also ignored.
REQ-018 In READ, a read is issued (address advances) only when FIFO occupancy plus in-flight reads is less than FIFO_DEPTH.
REQ-019 Issued addresses run 0..24 once, strictly increasing, without repeats or gaps; address 25..31 is never driven.
REQ-020 Row and column are tracked by counters: col wraps 4->0 and increments row; no divide or modulo logic.
REQ-021 Each captured data_out is pushed into the FIFO with its row, col and last tag in the cycle after issue.
REQ-022 A beat transfers when m_valid and m_ready are both high; m_data, m_row, m_col and m_last are held stable while m_valid is high and m_ready is low.
REQ-023 Simultaneous push and pop is allowed at every occupancy, including full and empty; occupancy is unchanged.
REQ-024 Minimum latency: with m_ready held high, start at cycle 0 yields address 0 at cycle 1 and the first m_valid at cycle 3.
REQ-025 Throughput: with m_ready held high, one beat per cycle in steady state.
REQ-026 checksum is cleared on the accepted start and accumulates each transferred m_data, wrapping at 2^32.
REQ-027 The address output holds its last value when no read is issued.

Reset
REQ-028 Reset values: state IDLE, busy 0, done 0, address 0, m_valid 0, m_data 0, m_row 0, m_col 0, m_last 0, checksum 0, FIFO empty, in-flight count 0.
REQ-029 Reset asserted mid-sweep aborts the sweep on the next edge: FIFO flushed, in-flight data discarded, no done pulse; reset dominates start.

Structure
REQ-030 N, FIFO_DEPTH defaults, the state encoding and the element-tag record (row, col, last) are placed in the shared package la5_pkg.
REQ-031 The FIFO is a separate sub-module, la5_sync_fifo (synchronous, parameterised width and depth, full/empty flags), instantiated once.

Verification
REQ-032 Upstream model returns data_out = 3*address + 1; m_ready held at 1; start once -> 25 beats with values 1, 4, ..., 73 in row-major order, m_last only on (4,4), checksum = 925, done on the cycle after the last beat.
REQ-033 m_ready held at 0 for 20 cycles after start -> exactly 4 reads issued, address stalls at 3, m_data holds 1; after m_ready is released, all 25 beats arrive in order with no loss or duplication.
REQ-034 m_ready toggled pseudo-randomly (seed 1) -> the sequence and checksum are identical to REQ-032 and no output changes while stalled.
REQ-035 start pulsed again at beat 10 and on the done cycle -> ignored; exactly 25 beats and one done pulse.
REQ-036 reset pulsed after beat 12, then a new start -> outputs return to reset values, no done for the aborted sweep; the new sweep restarts at address 0 with checksum 925.
REQ-037 data_out = 0xFFFFFFFF for every address -> checksum = 0xFFFFFFE7 (wrap-around check).

Source files
------------

// File: rtl/la5_pkg.sv
// Shared definitions for the LA5 result-matrix stream reader: sizes, FSM
// encoding, the per-element tag record and the row/col stepping helper.
package la5_pkg;

  localparam int N_DEF          = 5;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int ADDR_W         = 5;
  localparam int COORD_W        = 3;
  localparam int DATA_W         = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic               last;
  } tag_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    tag_t              tag;
  } elem_t;

  // Steps (row, col) in row-major order with counters only; last marks (n-1, n-1).
  function automatic tag_t nextTag(input tag_t cur, input int n);
    tag_t nxt;
    nxt = cur;
    if (cur.col == COORD_W'(n - 1)) begin
      nxt.col = '0;
      nxt.row = cur.row + 1'b1;
    end else begin
      nxt.col = cur.col + 1'b1;
    end
    nxt.last = (nxt.row == COORD_W'(n - 1)) && (nxt.col == COORD_W'(n - 1));
    return nxt;
  endfunction

endpackage

// File: rtl/la5_sync_fifo.sv
// Small synchronous FIFO with occupancy count; push and pop in the same
// cycle are accepted at any occupancy, including full.
module la5_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W:0]   count_q;
  logic             wrEn;
  logic             rdEn;

  assign full  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rdPtr_q];

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign rdEn = pop & ~empty;
  assign wrEn = push & (~full | rdEn);

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem_q[wrPtr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (wrEn) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (rdEn) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({wrEn, rdEn})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/la5_stream_reader.sv
// Sweeps the N x N LA5 result port in row-major order and streams each
// element with its coordinates over a valid/ready interface, summing them.
module la5_stream_reader
  import la5_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  address,
  input  logic [DATA_W-1:0]  data_out,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [DATA_W-1:0]  m_data,
  output logic [COORD_W-1:0] m_row,
  output logic [COORD_W-1:0] m_col,
  output logic               m_last,
  output logic [DATA_W-1:0]  checksum
);

  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N * N - 1);
  localparam tag_t              FIRST_TAG = '{row: '0, col: '0, last: 1'(N == 1)};

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr_q;
  tag_t              tag_q;
  logic              issue_q;
  logic [ADDR_W-1:0] nxtAddr_q;
  tag_t              nxtTag_q;
  logic              push_q;
  tag_t              pushTag_q;
  logic [DATA_W-1:0] checksum_q;
  logic [DATA_W-1:0] checksum_d;

  elem_t             fifoWdata;
  elem_t             fifoRdata;
  logic              fifoPush;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [CNT_W-1:0]  fifoCount;
  logic              pop;
  logic              lastPop;
  logic              startOk;
  logic              canIssue;
  logic [CNT_W:0]    committed;

  la5_sync_fifo #(
    .WIDTH ($bits(elem_t)),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifoPush),
    .wdata (fifoWdata),
    .pop   (pop),
    .rdata (fifoRdata),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  assign m_valid   = ~fifoEmpty;
  assign pop       = m_valid & m_ready;
  assign lastPop   = pop & fifoRdata.tag.last;
  assign fifoPush  = push_q & (~fifoFull | pop);
  assign fifoWdata = '{data: data_out, tag: pushTag_q};

  assign m_data = m_valid ? fifoRdata.data     : '0;
  assign m_row  = m_valid ? fifoRdata.tag.row  : '0;
  assign m_col  = m_valid ? fifoRdata.tag.col  : '0;
  assign m_last = m_valid ? fifoRdata.tag.last : 1'b0;

  // Slots already promised: buffered entries plus reads still travelling from
  // the upstream port, less the head leaving this cycle.
  assign committed = {1'b0, fifoCount}
                   + {{CNT_W{1'b0}}, push_q}
                   + {{CNT_W{1'b0}}, issue_q}
                   - {{CNT_W{1'b0}}, pop};
  assign canIssue  = (state_q == ST_READ) && (committed < (CNT_W + 1)'(FIFO_DEPTH));
  assign startOk   = (state_q == ST_IDLE) && start && !done_q;
  assign checksum_d = checksum_q + m_data;

  assign busy     = busy_q;
  assign done     = done_q;
  assign address  = addr_q;
  assign checksum = checksum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= '0;
      tag_q      <= '0;
      issue_q    <= 1'b0;
      nxtAddr_q  <= '0;
      nxtTag_q   <= '0;
      push_q     <= 1'b0;
      pushTag_q  <= '0;
      checksum_q <= '0;
    end else begin
      done_q    <= 1'b0;
      issue_q   <= 1'b0;
      push_q    <= issue_q;
      pushTag_q <= tag_q;
      if (pop) begin
        checksum_q <= checksum_d;
      end
      case (state_q)
        ST_IDLE: begin
          // Address 0 is presented in the first busy cycle, so the start edge issues it.
          if (startOk) begin
            state_q    <= (LAST_ADDR == '0) ? ST_DRAIN : ST_READ;
            busy_q     <= 1'b1;
            addr_q     <= '0;
            tag_q      <= FIRST_TAG;
            issue_q    <= 1'b1;
            nxtAddr_q  <= ADDR_W'(1);
            nxtTag_q   <= nextTag(FIRST_TAG, N);
            checksum_q <= '0;
          end
        end
        ST_READ: begin
          if (canIssue) begin
            addr_q    <= nxtAddr_q;
            tag_q     <= nxtTag_q;
            issue_q   <= 1'b1;
            nxtAddr_q <= nxtAddr_q + 1'b1;
            nxtTag_q  <= nextTag(nxtTag_q, N);
            if (nxtAddr_q == LAST_ADDR) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (lastPop) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_la5_stream_reader.sv
// Directed bench for la5_stream_reader: an upstream model returning 3*addr+1
// (or all ones), a beat monitor with its own row-major model, and sweep vectors.
module tb_la5_stream_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  address;
  logic [31:0] data_out;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [2:0]  m_row;
  logic [2:0]  m_col;
  logic        m_last;
  logic [31:0] checksum;

  la5_stream_reader #(.N(5), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .address  (address),
    .data_out (data_out),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_row    (m_row),
    .m_col    (m_col),
    .m_last   (m_last),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          readyMode;
    bit          allOnes;
    bit          extraStarts;
    logic [31:0] expSum;
    int          expBeats;
  } vec_t;

  vec_t        vecs[5];
  int          checks = 0;
  int          errors = 0;
  bit          allOnes = 1'b0;
  int          readyMode = 0;
  logic [15:0] lfsr = 16'h0001;
  logic [31:0] expSum = 32'd925;
  int          beatCnt = 0;
  int          doneCnt = 0;
  int          cycle = 0;
  int          lastBeatCycle = 0;
  bit          prevStall = 1'b0;
  logic [31:0] prevData = '0;
  logic [6:0]  prevTag = '0;
  logic [4:0]  prevAddr = '0;

  // Upstream result port: data for the address presented in one cycle appears in the next.
  always @(posedge clk) begin
    data_out <= allOnes ? 32'hFFFF_FFFF : 32'(3 * int'(address) + 1);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Beat monitor: in-order model of the row-major stream, stall stability, done timing.
  always @(negedge clk) begin
    logic [31:0] eData;
    logic [6:0]  eTag;
    cycle++;
    if (reset) begin
      prevStall = 1'b0;
      prevAddr  = '0;
    end else begin
      if (prevStall) begin
        checkOutput("stallValid", 32'(m_valid), 32'd1);
        checkOutput("stallData", m_data, prevData);
        checkOutput("stallTag", 32'({m_row, m_col, m_last}), 32'(prevTag));
      end
      if (address !== prevAddr) begin
        checkOutput("addrRange", 32'(address <= 5'd24), 32'd1);
        if (address != 5'd0) begin
          checkOutput("addrStep", 32'(address), 32'(5'(prevAddr + 5'd1)));
        end
      end
      prevAddr = address;
      if (m_valid && m_ready) begin
        if (beatCnt >= 25) begin
          checkOutput("extraBeat", 32'(beatCnt), 32'd24);
        end else begin
          eData = allOnes ? 32'hFFFF_FFFF : 32'(3 * beatCnt + 1);
          eTag  = {3'(beatCnt / 5), 3'(beatCnt % 5), beatCnt == 24};
          checkOutput("beatData", m_data, eData);
          checkOutput("beatTag", 32'({m_row, m_col, m_last}), 32'(eTag));
        end
        beatCnt++;
        lastBeatCycle = cycle;
      end
      if (done) begin
        doneCnt++;
        checkOutput("doneTiming", 32'(cycle - lastBeatCycle), 32'd1);
        checkOutput("doneBeats", 32'(beatCnt), 32'd25);
        checkOutput("doneSum", checksum, expSum);
      end
      prevStall = m_valid && !m_ready;
      prevData  = m_data;
      prevTag   = {m_row, m_col, m_last};
    end
  end

  // Advance one cycle and drive inputs just after the rising edge.
  task automatic applyStimulus(input bit s);
    @(posedge clk);
    #1;
    start = s;
    case (readyMode)
      0:       m_ready = 1'b1;
      1:       m_ready = lfsr[0];
      default: m_ready = 1'b0;
    endcase
    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  endtask

  task automatic waitDone(input bit extra, input string name);
    bit sawDone = 1'b0;
    bit midDone = 1'b0;
    int n = 0;
    while (!sawDone && n < 2000) begin
      applyStimulus(1'b0);
      n++;
      if (extra && !midDone && beatCnt >= 10) begin
        start   = 1'b1;
        midDone = 1'b1;
      end
      if (done) begin
        sawDone = 1'b1;
        if (extra) start = 1'b1;
      end
    end
    checkOutput({name, "_doneSeen"}, 32'(sawDone), 32'd1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0);
  endtask

  task automatic beginSweep(input int mode, input bit ones, input logic [31:0] sum);
    readyMode = mode;
    allOnes   = ones;
    expSum    = sum;
    lfsr      = 16'h0001;
    beatCnt   = 0;
    doneCnt   = 0;
    applyStimulus(1'b1);
  endtask

  task automatic checkSweepEnd(input string name, input int expBeats);
    checkOutput({name, "_beats"}, 32'(beatCnt), 32'(expBeats));
    checkOutput({name, "_doneCount"}, 32'(doneCnt), 32'd1);
    checkOutput({name, "_checksum"}, checksum, expSum);
    checkOutput({name, "_busyLow"}, 32'(busy), 32'd0);
    checkOutput({name, "_validLow"}, 32'(m_valid), 32'd0);
  endtask

  task automatic checkResetState(input string name);
    checkOutput({name, "_busy"}, 32'(busy), 32'd0);
    checkOutput({name, "_done"}, 32'(done), 32'd0);
    checkOutput({name, "_address"}, 32'(address), 32'd0);
    checkOutput({name, "_valid"}, 32'(m_valid), 32'd0);
    checkOutput({name, "_data"}, m_data, 32'd0);
    checkOutput({name, "_rowCol"}, 32'({m_row, m_col, m_last}), 32'd0);
    checkOutput({name, "_checksum"}, checksum, 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{readyMode: 0, allOnes: 1'b0, extraStarts: 1'b0, expSum: 32'd925,        expBeats: 25};
    vecs[1] = '{readyMode: 1, allOnes: 1'b0, extraStarts: 1'b0, expSum: 32'd925,        expBeats: 25};
    vecs[2] = '{readyMode: 0, allOnes: 1'b0, extraStarts: 1'b1, expSum: 32'd925,        expBeats: 25};
    vecs[3] = '{readyMode: 0, allOnes: 1'b1, extraStarts: 1'b0, expSum: 32'hFFFF_FFE7, expBeats: 25};
    vecs[4] = '{readyMode: 1, allOnes: 1'b1, extraStarts: 1'b1, expSum: 32'hFFFF_FFE7, expBeats: 25};

    reset   = 1'b1;
    start   = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkResetState("reset");

    for (int i = 0; i < 5; i++) begin
      $display("[TB] sweep vector %0d", i);
      beginSweep(vecs[i].readyMode, vecs[i].allOnes, vecs[i].expSum);
      waitDone(vecs[i].extraStarts, $sformatf("vec%0d", i));
      checkSweepEnd($sformatf("vec%0d", i), vecs[i].expBeats);
    end

    $display("[TB] minimum latency");
    beginSweep(0, 1'b0, 32'd925);
    applyStimulus(1'b0);
    checkOutput("lat_c1_address", 32'(address), 32'd0);
    checkOutput("lat_c1_busy", 32'(busy), 32'd1);
    checkOutput("lat_c1_valid", 32'(m_valid), 32'd0);
    applyStimulus(1'b0);
    checkOutput("lat_c2_valid", 32'(m_valid), 32'd0);
    applyStimulus(1'b0);
    checkOutput("lat_c3_valid", 32'(m_valid), 32'd1);
    checkOutput("lat_c3_data", m_data, 32'd1);
    waitDone(1'b0, "lat");
    checkSweepEnd("lat", 25);

    $display("[TB] downstream stalled for 20 cycles");
    beginSweep(2, 1'b0, 32'd925);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0);
    checkOutput("stall_address", 32'(address), 32'd3);
    checkOutput("stall_valid", 32'(m_valid), 32'd1);
    checkOutput("stall_data", m_data, 32'd1);
    checkOutput("stall_rowCol", 32'({m_row, m_col, m_last}), 32'd0);
    checkOutput("stall_beats", 32'(beatCnt), 32'd0);
    readyMode = 0;
    waitDone(1'b0, "stall");
    checkSweepEnd("stall", 25);

    $display("[TB] reset mid-sweep");
    beginSweep(0, 1'b0, 32'd925);
    n = 0;
    while (beatCnt < 12 && n < 200) begin
      applyStimulus(1'b0);
      n++;
    end
    checkOutput("abort_reached12", 32'(beatCnt >= 12), 32'd1);
    reset = 1'b1;
    start = 1'b1;
    applyStimulus(1'b0);
    reset = 1'b0;
    checkResetState("abort");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0);
    checkOutput("abort_noDone", 32'(doneCnt), 32'd0);
    checkOutput("abort_idle", 32'(busy), 32'd0);
    beginSweep(0, 1'b0, 32'd925);
    applyStimulus(1'b0);
    checkOutput("restart_address", 32'(address), 32'd0);
    checkOutput("restart_checksumClear", checksum, 32'd0);
    waitDone(1'b0, "restart");
    checkSweepEnd("restart", 25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
